pipe_bus_arbiter: RTL

Arbitrates the single shared memory bus between the instruction-fetch stage and the MEM stage. MEM is the stage fed by the EX/MEM register, so its inputs are mem_aluop, mem_mem_addr and mem_reg2. The block sequences one bus transaction at a time with a req/ack handshake and a timeout watchdog. It generates the 6-bit pipeline stall vector that freezes the PC and the pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) while an access is outstanding. It sits beside the stall controller, and its stall vector is ORed into the global stall.

---
 rtl/pipe_bus_arbiter_if.sv | 40 ++++
 rtl/pipe_bus_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pipe_bus_arbiter_if.sv
// Request/response and shared-bus signals between the fetch/MEM stages, the arbiter and the bus slave.
// Pure wiring bundle, no latency; flow control is the req/done and cyc/ack handshakes it carries.
// master = arbiter side, slave = pipeline stages and bus slave.
interface pipe_bus_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_sel;
    logic        flush;
    logic        bus_cyc;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_sel;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic [31:0] if_rdata;
    logic        if_done;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        bus_err;
    logic [5:0]  stall;

    modport master (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_sel, flush,
        input  bus_ack, bus_rdata,
        output bus_cyc, bus_we, bus_addr, bus_wdata, bus_sel,
        output if_rdata, if_done, mem_rdata, mem_done, bus_err, stall
    );

    modport slave (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_sel, flush,
        output bus_ack, bus_rdata,
        input  bus_cyc, bus_we, bus_addr, bus_wdata, bus_sel,
        input  if_rdata, if_done, mem_rdata, mem_done, bus_err, stall
    );
endinterface

// File: rtl/pipe_bus_arbiter.sv
// Shares one memory bus between instruction fetch and the MEM stage, data first, with a timeout watchdog.
// Latency: bus_cyc one cycle after a sampled request; done pulse one cycle after bus_ack (2 cycles minimum).
// Backpressure: requesters hold req until done; stall vector freezes the pipeline while an access is pending.
module pipe_bus_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input logic                clk,
    input logic                rst,
    pipe_bus_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IFETCH  = 2'd1,
        DACCESS = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wd;
    logic             expire;

    logic             cyc_q;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       sel_q;
    logic [31:0]      if_rdata_q;
    logic [31:0]      mem_rdata_q;
    logic             if_done_q;
    logic             mem_done_q;
    logic             err_q;
    logic [5:0]       stall_c;

    assign expire = (wd == WD_LAST) && !bus.bus_ack;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.mem_req)                    state_nxt = DACCESS;
                else if (bus.if_req && !bus.flush)  state_nxt = IFETCH;
            end
            IFETCH: begin
                if (bus.flush || bus.bus_ack || expire) state_nxt = IDLE;
            end
            DACCESS: begin
                if (bus.bus_ack || expire) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bus drive, capture registers and the watchdog share the state decode above.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            sel_q       <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            err_q       <= 1'b0;
            wd          <= '0;
        end else begin
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
            err_q      <= 1'b0;
            unique case (state)
                IDLE: begin
                    wd <= '0;
                    if (bus.mem_req) begin
                        cyc_q   <= 1'b1;
                        we_q    <= bus.mem_we;
                        addr_q  <= bus.mem_addr;
                        wdata_q <= bus.mem_wdata;
                        sel_q   <= bus.mem_sel;
                    end else if (bus.if_req && !bus.flush) begin
                        cyc_q  <= 1'b1;
                        we_q   <= 1'b0;
                        addr_q <= bus.if_addr;
                        sel_q  <= 4'hF;
                    end
                end
                IFETCH: begin
                    // A flush wins over a same-cycle ack or timeout: the fetch is simply dropped.
                    if (bus.flush) begin
                        cyc_q <= 1'b0;
                    end else if (bus.bus_ack) begin
                        cyc_q      <= 1'b0;
                        if_rdata_q <= bus.bus_rdata;
                        if_done_q  <= 1'b1;
                    end else if (expire) begin
                        cyc_q      <= 1'b0;
                        if_rdata_q <= '0;
                        if_done_q  <= 1'b1;
                        err_q      <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                DACCESS: begin
                    if (bus.bus_ack) begin
                        cyc_q      <= 1'b0;
                        mem_done_q <= 1'b1;
                        if (!we_q) mem_rdata_q <= bus.bus_rdata;
                    end else if (expire) begin
                        cyc_q       <= 1'b0;
                        mem_rdata_q <= '0;
                        mem_done_q  <= 1'b1;
                        err_q       <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                default: cyc_q <= 1'b0;
            endcase
        end
    end

    // A fetch queued behind a data access sees the full data stall.
    always_comb begin
        stall_c = 6'b000000;
        if (rst)
            stall_c = 6'b000000;
        else if (bus.mem_req && !mem_done_q)
            stall_c = 6'b011111;
        else if (bus.if_req && !if_done_q && !bus.flush)
            stall_c = 6'b000011;
    end

    assign bus.bus_cyc   = cyc_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_sel   = sel_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.mem_done  = mem_done_q;
    assign bus.bus_err   = err_q;
    assign bus.stall     = stall_c;
endmodule
